fd_pipe_ctrl: RTL and testbench
===============================

Name: fd_pipe_ctrl

Overview:
Fetch-side consumer for the Y86-64 five-stage pipeline. It holds the F register (F_predPC), which feeds fetch, and latches the fetch outputs into the D pipeline register. It also computes the hazard controls: load/use stall, ret bubble and mispredicted-branch bubble. Sits between the fetch stage and decode, with E/M/W feedback as inputs; also keeps stall/bubble performance counters.

Parameters:
RESET_PC, 64'd0, value loaded into F_predPC on reset
CNT_W, 32, width of the stall and bubble counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
f_predPC  in  64  predicted next PC from fetch
f_stat  in  3  fetch status, one-hot: bit0 halt, bit1 invalid instr, bit2 imem error; 0 = AOK
f_icode  in  4  fetched icode
f_ifun  in  4  fetched ifun
f_rA  in  4  fetched rA
f_rB  in  4  fetched rB
f_valC  in  64  fetched constant
f_valP  in  64  fetched next sequential PC
d_srcA  in  4  decode source A, from the decode combinational logic
d_srcB  in  4  decode source B
E_icode  in  4  icode in E register
E_dstM  in  4  dstM in E register
e_Cnd  in  1  branch condition from execute
M_icode  in  4  icode in M register
W_stat  in  3  status in W register
F_predPC  out  64  F register
D_stat  out  3  D register fields
D_icode  out  4
D_ifun  out  4
D_rA  out  4
D_rB  out  4
D_valC  out  64
D_valP  out  64
F_stall  out  1  combinational control
D_stall  out  1
D_bubble  out  1
E_bubble  out  1
stall_cnt  out  CNT_W  cycles with D_stall=1
bubble_cnt  out  CNT_W  cycles with D_bubble=1

Behaviour:
- Encodings: HALT 0, NOP 1, JXX 7, RET 9, MRMOVQ 5, POPQ B. RNONE = 4'hF.
- load_use = (E_icode==MRMOVQ or POPQ) and E_dstM!=RNONE and (E_dstM==d_srcA or E_dstM==d_srcB).
- ret_in_flight = RET in {D_icode, E_icode, M_icode}.
- mispredict = (E_icode==JXX and !e_Cnd).
- F_stall = load_use or ret_in_flight.
- D_stall = load_use.
- D_bubble = mispredict or (!load_use and ret_in_flight).
- E_bubble = mispredict or load_use.
- All four control outputs are combinational from current inputs and D state; they are 0 during reset cycles.
- Bubble value for D: stat 0, icode NOP, ifun 0, rA=rB=F, valC 0, valP 0.
- Register update priority at each rising edge, highest first:
  1. reset: F_predPC=RESET_PC, D=bubble, both counters 0.
  2. freeze (W_stat!=0): F and D hold; counters hold.
  3. F register: hold if F_stall, else load f_predPC.
  4. D register: hold if D_stall; else bubble if D_bubble; else load f_* fields.
- D_stall and D_bubble are mutually exclusive by construction; stall wins if both are forced.
- Counters: +1 on each non-reset, non-frozen cycle where the respective control is 1; saturate at all-ones (no wrap).
- Latency: fetch outputs appear on D_* one cycle after capture; F_predPC one cycle after f_predPC.
- Reset asserted mid-stall clears all state on that edge; the first cycle after deassertion is a normal load.

Test Plan:
- Reset: hold reset 2 cycles with f_predPC=64'h40 -> F_predPC=0, D_icode=1, D_rA=F, both counters 0. Release -> next edge F_predPC=64'h40.
- Load/use: E_icode=5, E_dstM=2, d_srcA=2, f_icode=6 -> F_stall=D_stall=E_bubble=1, D_bubble=0; F and D hold; stall_cnt+1. Same with E_dstM=F -> no stall.
- Ret: D_icode becomes 9, then ret moves through E and M -> F_stall=1 and D_bubble=1 for exactly 3 cycles; D_icode=1 at each of those edges; bubble_cnt=3.
- Mispredict: E_icode=7, e_Cnd=0 -> D_bubble=E_bubble=1, D_icode=1 next edge, F loads f_predPC. With e_Cnd=1 -> no bubbles.
- Load/use with ret in D (E_icode=B, E_dstM=3, d_srcB=3, D_icode=9) -> D_stall=1, D_bubble=0, D holds icode 9.
- Freeze: W_stat=3'b001 with new f_* values -> F_predPC, D_* and counters unchanged while W_stat!=0.

Source files
------------

// File: rtl/fd_pipe_ctrl.sv
// fd_pipe_ctrl: Y86-64 fetch/decode boundary.
// Holds the F register (predicted PC) and the D pipeline register, derives
// the load/use, ret and mispredict hazard controls from decode state and
// E/M/W feedback, and counts D stall and D bubble cycles.
module fd_pipe_ctrl #(
   parameter logic [63:0] RESET_PC = 64'd0,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [63:0]      f_predPC,
   input  logic [2:0]       f_stat,
   input  logic [3:0]       f_icode,
   input  logic [3:0]       f_ifun,
   input  logic [3:0]       f_rA,
   input  logic [3:0]       f_rB,
   input  logic [63:0]      f_valC,
   input  logic [63:0]      f_valP,
   input  logic [3:0]       d_srcA,
   input  logic [3:0]       d_srcB,
   input  logic [3:0]       E_icode,
   input  logic [3:0]       E_dstM,
   input  logic             e_Cnd,
   input  logic [3:0]       M_icode,
   input  logic [2:0]       W_stat,
   output logic [63:0]      F_predPC,
   output logic [2:0]       D_stat,
   output logic [3:0]       D_icode,
   output logic [3:0]       D_ifun,
   output logic [3:0]       D_rA,
   output logic [3:0]       D_rB,
   output logic [63:0]      D_valC,
   output logic [63:0]      D_valP,
   output logic             F_stall,
   output logic             D_stall,
   output logic             D_bubble,
   output logic             E_bubble,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_POPQ   = 4'hB;
   localparam logic [3:0] RNONE    = 4'hF;

   // Counters stick at all-ones instead of wrapping to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      if (&c) begin
         return c;
      end
      return c + 1'b1;
   endfunction

   logic load_use;
   logic ret_in_flight;
   logic mispredict;
   logic freeze;
   logic e_is_load;
   logic unused_halt;

   // HALT only matters through W_stat; kept named so the encoding table is complete.
   assign unused_halt = (I_HALT == 4'h0);

   // Hazard detection from the current D register and E/M feedback.
   always_comb begin
      e_is_load     = (E_icode == I_MRMOVQ) || (E_icode == I_POPQ);
      load_use      = e_is_load && (E_dstM != RNONE) &&
                      ((E_dstM == d_srcA) || (E_dstM == d_srcB));
      ret_in_flight = (D_icode == I_RET) || (E_icode == I_RET) ||
                      (M_icode == I_RET);
      mispredict    = (E_icode == I_JXX) && !e_Cnd;
      freeze        = (W_stat != 3'b000);
   end

   // Pipeline controls; forced low while reset is held so nothing downstream
   // reacts to stale register contents.
   always_comb begin
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      D_bubble = 1'b0;
      E_bubble = 1'b0;
      if (!reset) begin
         F_stall  = load_use || ret_in_flight;
         D_stall  = load_use;
         D_bubble = mispredict || (!load_use && ret_in_flight);
         E_bubble = mispredict || load_use;
      end
   end

   // F register: reset, then freeze, then stall-hold, else take the prediction.
   always_ff @(posedge clk) begin
      if (reset) begin
         F_predPC <= RESET_PC;
      end else if (!freeze && !F_stall) begin
         F_predPC <= f_predPC;
      end
   end

   // D register: stall takes precedence over bubble if both were ever raised.
   always_ff @(posedge clk) begin
      if (reset) begin
         D_stat  <= 3'b000;
         D_icode <= I_NOP;
         D_ifun  <= 4'h0;
         D_rA    <= RNONE;
         D_rB    <= RNONE;
         D_valC  <= 64'd0;
         D_valP  <= 64'd0;
      end else if (!freeze && !D_stall) begin
         if (D_bubble) begin
            D_stat  <= 3'b000;
            D_icode <= I_NOP;
            D_ifun  <= 4'h0;
            D_rA    <= RNONE;
            D_rB    <= RNONE;
            D_valC  <= 64'd0;
            D_valP  <= 64'd0;
         end else begin
            D_stat  <= f_stat;
            D_icode <= f_icode;
            D_ifun  <= f_ifun;
            D_rA    <= f_rA;
            D_rB    <= f_rB;
            D_valC  <= f_valC;
            D_valP  <= f_valP;
         end
      end
   end

   // Performance counters: count only cycles where the pipeline actually advances.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else if (!freeze) begin
         if (D_stall) begin
            stall_cnt <= sat_inc(stall_cnt);
         end
         if (D_bubble) begin
            bubble_cnt <= sat_inc(bubble_cnt);
         end
      end
   end

endmodule

// File: tb/tb_fd_pipe_ctrl.sv
// Directed bench for fd_pipe_ctrl: reset, load/use, ret, mispredict,
// load/use over ret, freeze and reset during a stall.
module tb_fd_pipe_ctrl;

   logic        clk;
   logic        reset;
   logic [63:0] f_predPC;
   logic [2:0]  f_stat;
   logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
   logic [63:0] f_valC, f_valP;
   logic [3:0]  d_srcA, d_srcB, E_icode, E_dstM, M_icode;
   logic        e_Cnd;
   logic [2:0]  W_stat;
   logic [63:0] F_predPC;
   logic [2:0]  D_stat;
   logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
   logic [63:0] D_valC, D_valP;
   logic        F_stall, D_stall, D_bubble, E_bubble;
   logic [31:0] stall_cnt, bubble_cnt;

   int passed = 0;
   int total  = 0;

   fd_pipe_ctrl #(.RESET_PC(64'd0), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .f_predPC(f_predPC), .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun),
      .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP),
      .d_srcA(d_srcA), .d_srcB(d_srcB), .E_icode(E_icode), .E_dstM(E_dstM),
      .e_Cnd(e_Cnd), .M_icode(M_icode), .W_stat(W_stat),
      .F_predPC(F_predPC), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
      .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
      .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic ctrl(input string tag, input logic fs, input logic ds,
                       input logic db, input logic eb);
      check({tag, ".F_stall"},  {63'd0, F_stall},  {63'd0, fs});
      check({tag, ".D_stall"},  {63'd0, D_stall},  {63'd0, ds});
      check({tag, ".D_bubble"}, {63'd0, D_bubble}, {63'd0, db});
      check({tag, ".E_bubble"}, {63'd0, E_bubble}, {63'd0, eb});
   endtask

   task automatic idle_back();
      E_icode = 4'h1; E_dstM = 4'hF; e_Cnd = 1'b0; M_icode = 4'h1;
      d_srcA = 4'hF; d_srcB = 4'hF; W_stat = 3'b000;
   endtask

   initial begin
      reset = 1'b1;
      idle_back();
      f_predPC = 64'h40; f_stat = 3'b000; f_icode = 4'h6; f_ifun = 4'h1;
      f_rA = 4'h2; f_rB = 4'h3; f_valC = 64'h1234; f_valP = 64'h4A;
      // load/use pattern present during reset: controls must stay low
      E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2;

      tick();
      tick();
      check("rst.F_predPC", F_predPC, 64'h0);
      check("rst.D_icode", {60'd0, D_icode}, 64'h1);
      check("rst.D_rA", {60'd0, D_rA}, 64'hF);
      check("rst.stall_cnt", {32'd0, stall_cnt}, 64'd0);
      check("rst.bubble_cnt", {32'd0, bubble_cnt}, 64'd0);
      ctrl("rst", 1'b0, 1'b0, 1'b0, 1'b0);

      // release: normal load
      reset = 1'b0;
      idle_back();
      tick();
      check("rel.F_predPC", F_predPC, 64'h40);
      check("rel.D_icode", {60'd0, D_icode}, 64'h6);
      check("rel.D_ifun", {60'd0, D_ifun}, 64'h1);
      check("rel.D_rB", {60'd0, D_rB}, 64'h3);
      check("rel.D_valC", D_valC, 64'h1234);
      check("rel.D_valP", D_valP, 64'h4A);

      // load/use: mrmovq into r2, decode reads r2
      E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2;
      f_predPC = 64'h50; f_icode = 4'h2; f_valC = 64'h0;
      settle();
      ctrl("lu", 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      check("lu.F_hold", F_predPC, 64'h40);
      check("lu.D_hold", {60'd0, D_icode}, 64'h6);
      check("lu.stall_cnt", {32'd0, stall_cnt}, 64'd1);
      E_dstM = 4'hF;
      settle();
      ctrl("lu_rnone", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check("lu2.F_predPC", F_predPC, 64'h50);
      check("lu2.D_icode", {60'd0, D_icode}, 64'h2);
      check("lu2.stall_cnt", {32'd0, stall_cnt}, 64'd1);

      // ret: fetch ret, then walk it through D, E, M
      idle_back();
      f_icode = 4'h9; f_predPC = 64'h5A;
      tick();
      check("ret.D_icode", {60'd0, D_icode}, 64'h9);
      f_icode = 4'h1; f_predPC = 64'h99;
      settle();
      ctrl("retD", 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      check("ret1.D_icode", {60'd0, D_icode}, 64'h1);
      E_icode = 4'h9;
      settle();
      ctrl("retE", 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      check("ret2.D_icode", {60'd0, D_icode}, 64'h1);
      E_icode = 4'h1; M_icode = 4'h9;
      settle();
      ctrl("retM", 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      check("ret3.D_icode", {60'd0, D_icode}, 64'h1);
      check("ret.F_hold", F_predPC, 64'h5A);
      check("ret.bubble_cnt", {32'd0, bubble_cnt}, 64'd3);
      M_icode = 4'h1; f_predPC = 64'h70;
      settle();
      ctrl("retdone", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check("retdone.F_predPC", F_predPC, 64'h70);

      // mispredicted jump
      E_icode = 4'h7; e_Cnd = 1'b0; f_icode = 4'h6; f_predPC = 64'h80;
      settle();
      ctrl("mis", 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      check("mis.D_icode", {60'd0, D_icode}, 64'h1);
      check("mis.F_predPC", F_predPC, 64'h80);
      check("mis.bubble_cnt", {32'd0, bubble_cnt}, 64'd4);
      e_Cnd = 1'b1; f_predPC = 64'h88;
      settle();
      ctrl("taken", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check("taken.D_icode", {60'd0, D_icode}, 64'h6);
      check("taken.F_predPC", F_predPC, 64'h88);

      // load/use with ret sitting in D: stall must beat the ret bubble
      idle_back();
      f_icode = 4'h9; f_predPC = 64'h90;
      tick();
      E_icode = 4'hB; E_dstM = 4'h3; d_srcB = 4'h3; f_icode = 4'h4;
      settle();
      ctrl("luret", 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      check("luret.D_icode", {60'd0, D_icode}, 64'h9);
      check("luret.stall_cnt", {32'd0, stall_cnt}, 64'd2);
      check("luret.bubble_cnt", {32'd0, bubble_cnt}, 64'd4);

      // freeze: W holds a halt, nothing moves and counters hold
      idle_back();
      W_stat = 3'b001; f_icode = 4'h3; f_predPC = 64'hA0; f_valP = 64'hFF;
      tick();
      tick();
      check("frz.F_predPC", F_predPC, 64'h90);
      check("frz.D_icode", {60'd0, D_icode}, 64'h9);
      check("frz.D_valP", D_valP, 64'h4A);
      check("frz.stall_cnt", {32'd0, stall_cnt}, 64'd2);
      check("frz.bubble_cnt", {32'd0, bubble_cnt}, 64'd4);

      // reset in the middle of a load/use stall
      W_stat = 3'b000;
      E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2;
      reset = 1'b1;
      tick();
      check("midrst.F_predPC", F_predPC, 64'h0);
      check("midrst.D_icode", {60'd0, D_icode}, 64'h1);
      check("midrst.stall_cnt", {32'd0, stall_cnt}, 64'd0);
      check("midrst.bubble_cnt", {32'd0, bubble_cnt}, 64'd0);
      reset = 1'b0;
      idle_back();
      f_predPC = 64'hB0; f_icode = 4'h6; f_stat = 3'b010;
      tick();
      check("post.F_predPC", F_predPC, 64'hB0);
      check("post.D_icode", {60'd0, D_icode}, 64'h6);
      check("post.D_stat", {61'd0, D_stat}, 64'h2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
